// File: rtl/coll_det_gen.sv
// coll_det_gen: predicts whether two bodies in linear motion pass within sqrt(r2), fixed 8-cycle latency.
// Optional macro COLL_DET_APPROACH_EN: only approaching bodies (dot<0) can raise trial.
module coll_det_gen #(
    parameter int W   = 16,
    parameter int LAT = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_rdy,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] y1,
    input  logic signed [W-1:0] x2,
    input  logic signed [W-1:0] y2,
    input  logic signed [W-1:0] vx1,
    input  logic signed [W-1:0] vy1,
    input  logic signed [W-1:0] vx2,
    input  logic signed [W-1:0] vy2,
    input  logic        [W-1:0] r2,
    output logic                busy,
    output logic                out_rdy,
    output logic                trial,
    output logic                closing
);
    localparam int DW = W + 1;      // differences
    localparam int SW = 2 * W + 3;  // r_sq, v_sq, dot
    localparam int MW = 2 * W + 4;  // multiplier operands
    localparam int PW = 2 * MW;     // multiplier products

    // State code equals cycles since accept, so DONE lands on LAT; only LAT=8 is legal.
    typedef enum logic [3:0] {
        IDLE = 4'd0, DIFF = 4'd1, SQA = 4'd2, SQB = 4'd3, DOT = 4'd4,
        SUM  = 4'd5, PROD = 4'd6, CMP = 4'd7, DONE = 4'(LAT)
    } state_t;

    state_t              state;
    logic signed [W-1:0] x1_q, y1_q, x2_q, y2_q, vx1_q, vy1_q, vx2_q, vy2_q;
    logic        [W-1:0] r2_q;
    logic signed [DW-1:0] dx, dy, dvx, dvy;
    logic        [SW-1:0] r_sq, v_sq;
    logic signed [SW-1:0] dot;
    logic signed [MW-1:0] dr;
    logic signed [PW-1:0] pa, pb;
    logic signed [MW-1:0] ma0, mb0, ma1, mb1;
    logic signed [PW-1:0] prod0, prod1;
    logic                 hit, approach, trial_next;

    function automatic logic signed [MW-1:0] ext(input logic signed [DW-1:0] v);
        return {{(MW - DW){v[DW-1]}}, v};
    endfunction

    // Operand steering for the two shared multipliers.
    always_comb begin
        ma0 = '0;
        mb0 = '0;
        ma1 = '0;
        mb1 = '0;
        case (state)
            SQA:  begin ma0 = ext(dx);  mb0 = ext(dx);  ma1 = ext(dy);  mb1 = ext(dy);  end
            SQB:  begin ma0 = ext(dvx); mb0 = ext(dvx); ma1 = ext(dvy); mb1 = ext(dvy); end
            DOT:  begin ma0 = ext(dx);  mb0 = ext(dvx); ma1 = ext(dy);  mb1 = ext(dvy); end
            PROD: begin
                ma0 = {1'b0, v_sq};
                mb0 = dr;
                ma1 = {dot[SW-1], dot};
                mb1 = {dot[SW-1], dot};
            end
            default: ;
        endcase
    end

    assign prod0 = ma0 * mb0;
    assign prod1 = ma1 * mb1;

    // m < n (m = r_sq*v_sq - dot^2, n = v_sq*r2) is rearranged to v_sq*(r_sq - r2) < dot^2,
    // so PROD holds pa = v_sq*dr and pb = dot^2; dr<0 covers the v_sq==0 case.
    assign hit      = (v_sq != '0) ? (pa < pb) : dr[MW-1];
    assign approach = dot[SW-1];

`ifdef COLL_DET_APPROACH_EN
    assign trial_next = hit & approach;
`else
    assign trial_next = hit;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            out_rdy <= 1'b0;
            trial   <= 1'b0;
            closing <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_rdy) begin
                    state <= DIFF;
                    busy  <= 1'b1;
                end
                DIFF: state <= SQA;
                SQA:  state <= SQB;
                SQB:  state <= DOT;
                DOT:  state <= SUM;
                SUM:  state <= PROD;
                PROD: state <= CMP;
                CMP: begin
                    state   <= DONE;
                    out_rdy <= 1'b1;
                    trial   <= trial_next;
                    closing <= approach;
                end
                DONE: begin
                    state   <= IDLE;
                    out_rdy <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers have no reset; each is written before the FSM reaches its reader.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: if (in_rdy) begin
                x1_q  <= x1;
                y1_q  <= y1;
                x2_q  <= x2;
                y2_q  <= y2;
                vx1_q <= vx1;
                vy1_q <= vy1;
                vx2_q <= vx2;
                vy2_q <= vy2;
                r2_q  <= r2;
            end
            DIFF: begin
                dx  <= {x1_q[W-1], x1_q} - {x2_q[W-1], x2_q};
                dy  <= {y1_q[W-1], y1_q} - {y2_q[W-1], y2_q};
                dvx <= {vx1_q[W-1], vx1_q} - {vx2_q[W-1], vx2_q};
                dvy <= {vy1_q[W-1], vy1_q} - {vy2_q[W-1], vy2_q};
            end
            SQA: begin
                pa <= prod0;
                pb <= prod1;
            end
            SQB: begin
                r_sq <= pa[SW-1:0] + pb[SW-1:0];
                pa   <= prod0;
                pb   <= prod1;
            end
            DOT: begin
                v_sq <= pa[SW-1:0] + pb[SW-1:0];
                pa   <= prod0;
                pb   <= prod1;
            end
            SUM: begin
                dot <= pa[SW-1:0] + pb[SW-1:0];
                dr  <= {1'b0, r_sq} - {{(MW - W){1'b0}}, r2_q};
            end
            PROD: begin
                pa <= prod0;
                pb <= prod1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coll_det_gen.sv
// tb_coll_det_gen: directed vector table, reset/throughput sequences and randomized ops vs a wide-integer model.
// Expectations follow COLL_DET_APPROACH_EN when the macro is defined for the build.
module tb_coll_det_gen;
    localparam int W = 16;

`ifdef COLL_DET_APPROACH_EN
    localparam logic APPR = 1'b1;
`else
    localparam logic APPR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, in_rdy;
    logic signed [W-1:0] x1, y1, x2, y2, vx1, vy1, vx2, vy2;
    logic        [W-1:0] r2;
    logic busy, out_rdy, trial, closing;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    coll_det_gen #(.W(W), .LAT(8)) dut (
        .clock(clock), .reset(reset), .in_rdy(in_rdy),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .vx1(vx1), .vy1(vy1), .vx2(vx2), .vy2(vy2),
        .r2(r2), .busy(busy), .out_rdy(out_rdy), .trial(trial), .closing(closing)
    );

    typedef struct {
        logic signed [W-1:0] x1, y1, x2, y2, vx1, vy1, vx2, vy2;
        logic        [W-1:0] r2;
        logic                trial;
        logic                closing;
    } vec_t;

    vec_t tbl[6];
    vec_t rv;
    logic t_got, c_got, t_exp, c_exp;
    int   cyc, pulses, last, guard;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int e, input int f, input int g, input int h,
                                input int r, input logic t, input logic cl);
        vec_t v;
        v.x1 = W'(a);  v.y1 = W'(b);  v.x2 = W'(c);  v.y2 = W'(d);
        v.vx1 = W'(e); v.vy1 = W'(f); v.vx2 = W'(g); v.vy2 = W'(h);
        v.r2 = W'(r);
        v.trial = t;
        v.closing = cl;
        return v;
    endfunction

    function automatic logic signed [127:0] wide(input logic signed [W-1:0] a);
        return a;
    endfunction

    // Reference: closest-approach test straight from the definitions, in 128-bit integers.
    function automatic void model(input vec_t v, output logic t, output logic c);
        logic signed [127:0] dx, dy, dvx, dvy, rsq, vsq, dt, m, n, rr;
        dx  = wide(v.x1) - wide(v.x2);
        dy  = wide(v.y1) - wide(v.y2);
        dvx = wide(v.vx1) - wide(v.vx2);
        dvy = wide(v.vy1) - wide(v.vy2);
        rr  = {112'd0, v.r2};
        rsq = dx * dx + dy * dy;
        vsq = dvx * dvx + dvy * dvy;
        dt  = dx * dvx + dy * dvy;
        m   = rsq * vsq - dt * dt;
        n   = vsq * rr;
        t   = (vsq != 0) ? (m < n) : (rsq < rr);
        c   = (dt < 0);
        if (APPR) t = t & c;
    endfunction

    function automatic logic signed [W-1:0] rnd(input int mode);
        int v;
        case (mode)
            0:       v = int'($urandom_range(0, 15)) - 8;
            1:       v = int'($urandom);
            default: v = ($urandom_range(0, 2) == 0) ? -32768 : (($urandom_range(0, 1) == 0) ? 32767 : 0);
        endcase
        return W'(v);
    endfunction

    // NOTE: bench drives inputs with blocking assignments #1 after the edge, away from DUT sampling.
    task automatic apply(input vec_t v);
        x1 = v.x1;   y1 = v.y1;   x2 = v.x2;   y2 = v.y2;
        vx1 = v.vx1; vy1 = v.vy1; vx2 = v.vx2; vy2 = v.vy2;
        r2 = v.r2;
    endtask

    // Issue one request from IDLE; cyc is the cycle index after the accepting edge where out_rdy shows.
    task automatic do_op(input vec_t v, output logic t, output logic c, output int n);
        apply(v);
        in_rdy = 1'b1;
        tick();
        in_rdy = 1'b0;
        n = 1;
        while (out_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        t = trial;
        c = closing;
    endtask

    initial begin
        tbl[0] = mk(0, 0, 10, 1, 1, 0, -1, 0, 4, 1'b1, 1'b1);
        tbl[1] = mk(0, 0, 10, 3, 1, 0, -1, 0, 4, 1'b0, 1'b1);
        tbl[2] = mk(0, 0, -10, 1, 1, 0, -1, 0, 4, ~APPR, 1'b0);
        tbl[3] = mk(1, 1, 0, 0, 5, 5, 5, 5, 4, ~APPR, 1'b0);
        tbl[4] = mk(1, 1, 0, 0, 5, 5, 5, 5, 2, 1'b0, 1'b0);
        tbl[5] = mk(32767, 0, -32768, 0, 32767, 0, -32768, 0, 65535, ~APPR, 1'b0);

        reset  = 1'b1;
        in_rdy = 1'b0;
        apply(tbl[0]);
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset out_rdy", out_rdy, 0);
        check("reset trial", trial, 0);
        check("reset closing", closing, 0);

        // in_rdy under reset must not start an operation
        in_rdy = 1'b1;
        tick();
        tick();
        check("reset priority busy", busy, 0);
        in_rdy = 1'b0;
        reset  = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i], t_got, c_got, cyc);
            check($sformatf("vec%0d trial", i), t_got, tbl[i].trial);
            check($sformatf("vec%0d closing", i), c_got, tbl[i].closing);
            check($sformatf("vec%0d latency", i), cyc, 8);
            tick();
            check($sformatf("vec%0d pulse width", i), out_rdy, 0);
            check($sformatf("vec%0d busy after done", i), busy, 0);
            check($sformatf("vec%0d trial held", i), trial, tbl[i].trial);
        end

        // in_rdy held high: one accept per 9 cycles, extra requests not queued
        apply(tbl[5]);
        in_rdy = 1'b1;
        pulses = 0;
        last   = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (out_rdy) begin
                pulses++;
                if (last >= 0) check("throughput gap", k - last, 9);
                check("throughput trial", trial, tbl[5].trial);
                last = k;
            end
        end
        in_rdy = 1'b0;
        check("throughput pulses", pulses, 4);
        guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        check("throughput drain", busy, 0);
        tick();

        // reset during SQB aborts the operation
        apply(tbl[0]);
        in_rdy = 1'b1;
        tick();
        in_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort out_rdy", out_rdy, 0);
        check("abort trial", trial, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_rdy) pulses++;
        end
        check("abort no result", pulses, 0);
        do_op(tbl[0], t_got, c_got, cyc);
        check("post-abort trial", t_got, 1);
        check("post-abort closing", c_got, 1);
        check("post-abort latency", cyc, 8);
        tick();

        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = i % 3;
            rv.x1 = rnd(mode);  rv.y1 = rnd(mode);  rv.x2 = rnd(mode);  rv.y2 = rnd(mode);
            rv.vx1 = rnd(mode); rv.vy1 = rnd(mode); rv.vx2 = rnd(mode); rv.vy2 = rnd(mode);
            rv.r2 = (mode == 0) ? W'($urandom_range(0, 60)) : W'($urandom);
            model(rv, t_exp, c_exp);
            do_op(rv, t_got, c_got, cyc);
            check($sformatf("rand%0d trial", i), t_got, t_exp);
            check($sformatf("rand%0d closing", i), c_got, c_exp);
            check($sformatf("rand%0d latency", i), cyc, 8);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
